// File: rtl/hazard_unit.sv
// Hazard and forwarding controller: tracks in-flight register writes in a tag pipeline
// (E, M1..M<MEM_LAT>, W) and derives forwarding selects, load-use stalls and branch flushes.
module hazard_unit #(
  parameter int unsigned RA_W    = 4,
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [RA_W-1:0]  RA1D,
  input  logic [RA_W-1:0]  RA2D,
  input  logic [RA_W-1:0]  WA3D,
  input  logic             RegWriteD,
  input  logic             MemtoRegD,
  input  logic             BranchTakenE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [RA_W-1:0] PcReg = RA_W'(15);

  typedef struct packed {
    logic            valid;
    logic            rw;
    logic            ld;
    logic [RA_W-1:0] wa;
  } tag_t;

  tag_t            tag_e_q, tag_e_d;
  logic [RA_W-1:0] ra1_e_q, ra1_e_d;
  logic [RA_W-1:0] ra2_e_q, ra2_e_d;
  tag_t            tag_m_q [MEM_LAT];
  tag_t            tag_m_d [MEM_LAT];
  tag_t            tag_w_q, tag_w_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic ld_stall;
  logic [1:0] fwd_a, fwd_b;

  // R15 is the PC and is never treated as a tracked destination.
  function automatic logic tag_writes(input tag_t t, input logic [RA_W-1:0] r);
    return t.valid & t.rw & (t.wa == r) & (r != PcReg);
  endfunction

  function automatic logic [1:0] fwd_sel(input tag_t m1, input tag_t w,
                                         input logic [RA_W-1:0] r);
    logic [1:0] sel;
    sel = 2'b00;
    if (tag_writes(m1, r) && !m1.ld) begin
      sel = 2'b10;
    end else if (tag_writes(w, r)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  // A load in E, or any writer in M1..M(MEM_LAT-1), cannot be forwarded to the
  // instruction entering E next cycle.
  always_comb begin
    ld_stall = tag_e_q.ld & (tag_writes(tag_e_q, RA1D) | tag_writes(tag_e_q, RA2D));
    for (int k = 0; k < int'(MEM_LAT) - 1; k++) begin
      ld_stall = ld_stall | tag_writes(tag_m_q[k], RA1D) | tag_writes(tag_m_q[k], RA2D);
    end
  end

  always_comb begin
    fwd_a = fwd_sel(tag_m_q[0], tag_w_q, ra1_e_q);
    fwd_b = fwd_sel(tag_m_q[0], tag_w_q, ra2_e_q);
  end

  // Branch overrides stall; reset forces a full flush with no stall or forwarding.
  always_comb begin
    StallD    = ~reset & ld_stall & ~BranchTakenE;
    StallF    = StallD;
    FlushD    = reset | BranchTakenE;
    FlushE    = reset | ld_stall | BranchTakenE;
    ForwardAE = reset ? 2'b00 : fwd_a;
    ForwardBE = reset ? 2'b00 : fwd_b;
  end

  always_comb begin
    tag_e_d = '0;
    ra1_e_d = '0;
    ra2_e_d = '0;
    if (!FlushE) begin
      tag_e_d.valid = 1'b1;
      tag_e_d.rw    = RegWriteD;
      tag_e_d.ld    = MemtoRegD;
      tag_e_d.wa    = WA3D;
      ra1_e_d       = RA1D;
      ra2_e_d       = RA2D;
    end
    tag_m_d[0] = tag_e_q;
    for (int k = 1; k < int'(MEM_LAT); k++) begin
      tag_m_d[k] = tag_m_q[k-1];
    end
    tag_w_d = tag_m_q[MEM_LAT-1];
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (StallD && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (BranchTakenE && !(&flush_cnt_q)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tag_e_q <= '0;
      ra1_e_q <= '0;
      ra2_e_q <= '0;
      for (int k = 0; k < int'(MEM_LAT); k++) begin
        tag_m_q[k] <= '0;
      end
      tag_w_q     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      tag_e_q <= tag_e_d;
      ra1_e_q <= ra1_e_d;
      ra2_e_q <= ra2_e_d;
      for (int k = 0; k < int'(MEM_LAT); k++) begin
        tag_m_q[k] <= tag_m_d[k];
      end
      tag_w_q     <= tag_w_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: three configurations share stimulus and are checked against
// an age-indexed history model of in-flight instructions.
module tb_hazard_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [3:0] ra1d, ra2d, wa3d;
  logic       rwd, ldd, br;

  logic sf1, sd1, fd1, fe1, sf3, sd3, fd3, fe3, sfs, sds, fds, fes;
  logic [1:0] fa1, fb1, fa3, fb3, fas, fbs;
  logic [15:0] sc1, fc1, sc3, fc3;
  logic [3:0]  scs, fcs;

  hazard_unit #(.RA_W(4), .MEM_LAT(1), .CNT_W(16)) u1 (
    .clk(clk), .reset(reset), .RA1D(ra1d), .RA2D(ra2d), .WA3D(wa3d), .RegWriteD(rwd),
    .MemtoRegD(ldd), .BranchTakenE(br), .StallF(sf1), .StallD(sd1), .FlushD(fd1),
    .FlushE(fe1), .ForwardAE(fa1), .ForwardBE(fb1), .stall_cnt(sc1), .flush_cnt(fc1));

  hazard_unit #(.RA_W(4), .MEM_LAT(3), .CNT_W(16)) u3 (
    .clk(clk), .reset(reset), .RA1D(ra1d), .RA2D(ra2d), .WA3D(wa3d), .RegWriteD(rwd),
    .MemtoRegD(ldd), .BranchTakenE(br), .StallF(sf3), .StallD(sd3), .FlushD(fd3),
    .FlushE(fe3), .ForwardAE(fa3), .ForwardBE(fb3), .stall_cnt(sc3), .flush_cnt(fc3));

  hazard_unit #(.RA_W(4), .MEM_LAT(2), .CNT_W(4)) us (
    .clk(clk), .reset(reset), .RA1D(ra1d), .RA2D(ra2d), .WA3D(wa3d), .RegWriteD(rwd),
    .MemtoRegD(ldd), .BranchTakenE(br), .StallF(sfs), .StallD(sds), .FlushD(fds),
    .FlushE(fes), .ForwardAE(fas), .ForwardBE(fbs), .stall_cnt(scs), .flush_cnt(fcs));

  int total = 0;
  int bad   = 0;

  // Reference model: per configuration, instruction history by age (0 = in E).
  int lat  [3] = '{1, 3, 2};
  int cmax [3] = '{65535, 65535, 15};
  bit hv  [3][6];
  bit hrw [3][6];
  bit hld [3][6];
  int hwa [3][6];
  int hra1[3][6];
  int hra2[3][6];
  int scnt[3];
  int fcnt[3];
  bit e_sd[3];
  bit e_fd[3];
  bit e_fe[3];
  int e_fa[3];
  int e_fb[3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit wr(int i, int age, int r);
    return hv[i][age] && hrw[i][age] && hwa[i][age] == r && r != 15;
  endfunction

  function automatic int fsel(int i, int r);
    if (wr(i, 1, r) && !hld[i][1]) return 2;
    if (wr(i, lat[i] + 1, r)) return 1;
    return 0;
  endfunction

  task automatic model_eval(int i);
    bit ls;
    int r1, r2;
    r1 = int'(ra1d);
    r2 = int'(ra2d);
    ls = hld[i][0] && (wr(i, 0, r1) || wr(i, 0, r2));
    for (int k = 1; k < lat[i]; k++) if (wr(i, k, r1) || wr(i, k, r2)) ls = 1;
    if (reset) begin
      e_sd[i] = 0; e_fd[i] = 1; e_fe[i] = 1; e_fa[i] = 0; e_fb[i] = 0;
    end else begin
      e_sd[i] = ls && !br;
      e_fd[i] = br;
      e_fe[i] = ls || br;
      e_fa[i] = fsel(i, hra1[i][0]);
      e_fb[i] = fsel(i, hra2[i][0]);
    end
  endtask

  task automatic model_step(int i);
    if (reset) begin
      for (int a = 0; a < 6; a++) begin
        hv[i][a] = 0; hrw[i][a] = 0; hld[i][a] = 0; hwa[i][a] = 0;
        hra1[i][a] = 0; hra2[i][a] = 0;
      end
      scnt[i] = 0;
      fcnt[i] = 0;
    end else begin
      for (int a = lat[i] + 1; a >= 1; a--) begin
        hv[i][a] = hv[i][a-1]; hrw[i][a] = hrw[i][a-1]; hld[i][a] = hld[i][a-1];
        hwa[i][a] = hwa[i][a-1]; hra1[i][a] = hra1[i][a-1]; hra2[i][a] = hra2[i][a-1];
      end
      if (e_fe[i]) begin
        hv[i][0] = 0; hrw[i][0] = 0; hld[i][0] = 0; hwa[i][0] = 0;
        hra1[i][0] = 0; hra2[i][0] = 0;
      end else begin
        hv[i][0] = 1; hrw[i][0] = rwd; hld[i][0] = ldd; hwa[i][0] = int'(wa3d);
        hra1[i][0] = int'(ra1d); hra2[i][0] = int'(ra2d);
      end
      if (e_sd[i] && scnt[i] < cmax[i]) scnt[i]++;
      if (br && fcnt[i] < cmax[i]) fcnt[i]++;
    end
  endtask

  task automatic cmp_one(input int i, input logic sf, input logic sd, input logic fd,
                         input logic fe, input logic [1:0] fa, input logic [1:0] fb,
                         input logic [15:0] sc, input logic [15:0] fc);
    string p;
    p = $sformatf("lat%0d", lat[i]);
    check({p, " StallF"}, sf, e_sd[i]);
    check({p, " StallD"}, sd, e_sd[i]);
    check({p, " FlushD"}, fd, e_fd[i]);
    check({p, " FlushE"}, fe, e_fe[i]);
    check({p, " ForwardAE"}, fa, e_fa[i]);
    check({p, " ForwardBE"}, fb, e_fb[i]);
    check({p, " stall_cnt"}, sc, scnt[i]);
    check({p, " flush_cnt"}, fc, fcnt[i]);
  endtask

  task automatic tick();
    for (int i = 0; i < 3; i++) model_eval(i);
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_step(i);
    #1;
  endtask

  task automatic cyc();
    for (int i = 0; i < 3; i++) model_eval(i);
    cmp_one(0, sf1, sd1, fd1, fe1, fa1, fb1, sc1, fc1);
    cmp_one(1, sf3, sd3, fd3, fe3, fa3, fb3, sc3, fc3);
    cmp_one(2, sfs, sds, fds, fes, fas, fbs, {12'd0, scs}, {12'd0, fcs});
    tick();
  endtask

  task automatic drive(input int a1, input int a2, input int w, input bit rw, input bit ld,
                       input bit b, input bit r);
    ra1d = 4'(a1); ra2d = 4'(a2); wa3d = 4'(w);
    rwd = rw; ldd = ld; br = b; reset = r;
    #1;
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rst_pulse();
    drive(0, 0, 0, 0, 0, 0, 1);
    cyc();
  endtask

  int pick;
  int rr [3];

  initial begin
    @(posedge clk);
    #1;
    // Reset held for two cycles; counters are unknown until the first edge.
    drive(0, 0, 0, 0, 0, 0, 1);
    tick();
    drive(3, 5, 7, 1, 1, 0, 1);
    check("rst FlushD", fd1, 1);
    check("rst FlushE", fe1, 1);
    check("rst StallD", sd1, 0);
    check("rst cnt", sc1, 0);
    cyc();
    nop();
    check("idle FlushE", fe1, 0);
    check("idle ForwardAE", fa1, 0);
    cyc();

    // ALU producer at distance 1
    rst_pulse();
    drive(0, 0, 3, 1, 0, 0, 0); cyc();
    drive(3, 0, 4, 1, 0, 0, 0);
    check("alu d1 lat3 nostall", sd3, 0);
    cyc();
    nop();
    check("alu d1 lat1 fwdA", fa1, 2);
    check("alu d1 lat3 fwdA", fa3, 2);
    cyc();
    repeat (5) cyc();

    // ALU producer at distance 2
    rst_pulse();
    drive(0, 0, 3, 1, 0, 0, 0); cyc();
    nop(); cyc();
    drive(3, 0, 4, 1, 0, 0, 0); cyc();
    nop();
    check("alu d2 lat1 fwdA", fa1, 1);
    cyc();

    // Load-use, one memory stage
    rst_pulse();
    drive(0, 0, 5, 1, 1, 0, 0); cyc();
    drive(0, 5, 6, 1, 0, 0, 0);
    check("lu1 StallF", sf1, 1);
    check("lu1 StallD", sd1, 1);
    check("lu1 FlushE", fe1, 1);
    cyc();
    drive(0, 5, 6, 1, 0, 0, 0);
    check("lu1 release", sd1, 0);
    cyc();
    nop();
    check("lu1 fwdB", fb1, 1);
    check("lu1 stall_cnt", sc1, 1);
    cyc();

    // Load-use, three memory stages
    rst_pulse();
    drive(0, 0, 5, 1, 1, 0, 0); cyc();
    for (int j = 0; j < 4; j++) begin
      drive(0, 5, 6, 1, 0, 0, 0);
      check($sformatf("lu3 stall c%0d", j), sd3, (j < 3) ? 1 : 0);
      cyc();
    end
    nop();
    check("lu3 fwdB", fb3, 1);
    check("lu3 stall_cnt", sc3, 3);
    cyc();

    // Branch in the same cycle as a load-use stall
    rst_pulse();
    drive(0, 0, 5, 1, 1, 0, 0); cyc();
    drive(5, 0, 6, 1, 0, 1, 0);
    check("br StallD", sd1, 0);
    check("br FlushD", fd1, 1);
    check("br FlushE", fe1, 1);
    cyc();
    nop();
    check("br flush_cnt", fc1, 1);
    check("br stall_cnt", sc1, 0);
    cyc();

    // R15 never forwards or stalls
    rst_pulse();
    drive(0, 0, 15, 1, 0, 0, 0); cyc();
    drive(15, 15, 0, 0, 0, 0, 0);
    check("r15 alu nostall", sd3, 0);
    cyc();
    nop();
    check("r15 fwdA", fa1, 0);
    cyc();
    drive(0, 0, 15, 1, 1, 0, 0); cyc();
    drive(15, 15, 0, 0, 0, 0, 0);
    check("r15 ld nostall", sd1, 0);
    cyc();

    // Self-dependent loads keep re-triggering stalls; 4-bit counter must saturate
    rst_pulse();
    repeat (48) begin
      drive(1, 1, 1, 1, 1, 0, 0);
      cyc();
    end
    nop();
    check("sat stall_cnt", scs, 15);
    cyc();

    // Randomized traffic over a small register set to provoke frequent hazards
    repeat (3000) begin
      for (int k = 0; k < 3; k++) begin
        pick = $urandom_range(0, 4);
        rr[k] = (pick == 4) ? 15 : (pick == 3) ? int'($urandom_range(0, 15)) : pick;
      end
      drive(rr[0], rr[1], rr[2], $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Parametrised hazard and forwarding controller for the pipelined ARM core with a configurable memory latency. It tracks every in-flight register write in a tag pipeline that advances in lockstep with the datapath. From these tags it produces the Execute-stage forwarding selects, the load-use stall, and the branch flushes. It also keeps saturating stall and flush counters for performance measurement.

## Interface
- `RA_W`, default 4: register address width (16 architectural registers).
- `MEM_LAT`, default 1: number of memory stages M1..M`MEM_LAT`, legal range 1–3.
- `CNT_W`, default 16: width of the performance counters.

Ports:
- `clk` input, 1 bit: the single clock; all state updates on its rising edge.
- `reset` input, 1 bit: synchronous, active-high.
- `RA1D`, `RA2D` input, `RA_W`: Decode source registers (Rn, Rm).
- `WA3D` input, `RA_W`: Decode destination register.
- `RegWriteD` input, 1 bit: the Decode instruction writes a register.
- `MemtoRegD` input, 1 bit: the Decode instruction is a load.
- `BranchTakenE` input, 1 bit: a branch resolved taken in Execute.
- `StallF`, `StallD` output, 1 bit: hold the PC and the F/D register.
- `FlushD`, `FlushE` output, 1 bit: clear the F/D and D/E registers.
- `ForwardAE`, `ForwardBE` output, 2 bits: operand select. 00 = register file, 01 = Writeback result, 10 = `ALUResultM` from M1.
- `stall_cnt`, `flush_cnt` output, `CNT_W`: saturating event counters.

## Operation
- Tag pipeline stages: E, M1..M`MEM_LAT`, W.
- Each tag holds {valid, rw, ld, wa[RA_W-1:0]}. Tag E additionally holds ra1 and ra2.
- All tags advance every cycle. The pipeline is never stalled at E or later.
- Tag E loading:
  - Normal cycle: E loads {1, `RegWriteD`, `MemtoRegD`, `WA3D`, `RA1D`, `RA2D`}.
  - `FlushE` cycle: E loads the bubble (valid=0, rw=0).
- A tag "writes r" when valid, rw=1, wa==r and r!=15. R15 never matches.
- Forwarding (combinational from tag E), for operand A using ra1 and likewise B using ra2:
  - 10 if M1 writes ra1 and M1.ld=0.
  - Else 01 if W writes ra1.
  - Else 00.
  - M1 has priority over W.
- Load-use stall `ldStall`: asserted when `RA1D` or `RA2D` is written by any of the following:
  - tag E with ld=1;
  - tag Mk for 1 ≤ k < `MEM_LAT`, any rw=1, load or not (those values are not forwardable next cycle).
  - For `MEM_LAT`=1 this reduces to the classic E-load check.
- Output equations:
  - `StallF` = `StallD` = `ldStall` & ~`BranchTakenE`.
  - `FlushD` = `BranchTakenE`.
  - `FlushE` = `ldStall` | `BranchTakenE`.
  - Branch wins over stall: the stalled instruction is on the wrong path and is flushed.
- Counters:
  - `stall_cnt` increments on every cycle with `StallD`=1.
  - `flush_cnt` increments on every cycle with `BranchTakenE`=1.
  - Both saturate at all-ones and never wrap.

## Timing
- Forwarding selects and stall/flush outputs are combinational from the tags and the D inputs, in the same cycle.
- Tag and counter updates are registered, 1-cycle latency.
- Reset (synchronous), on the first rising edge with `reset`=1:
  - all tags go to bubble;
  - counters go to 0.
- Outputs while `reset` is high:
  - `FlushD`=`FlushE`=1, so the datapath clears its pipeline registers;
  - `StallF`=`StallD`=0;
  - `Forward*E`=00.
- After reset with no traffic: all outputs are 0.
- Reset mid-stall: on the next edge all tags are bubbles. A pending load is forgotten and produces no stall afterwards.
- Stall duration for a dependent instruction directly behind a load: `MEM_LAT` cycles. Each cycle re-evaluates against the advanced tags.
- Simultaneous stall and branch in the same cycle: `StallD`=0, `FlushD`=`FlushE`=1. Only `flush_cnt` increments.
- A write to R15 (`WA3D`=15) never forwards and never stalls.

## Test plan
- Reset behaviour, `MEM_LAT`=1: hold `reset` for 2 cycles -> `FlushD`=`FlushE`=1, stalls 0, then all outputs 0, counters 0.
- ALU-to-ALU forwarding:
  - Issue ADD R3 (`RegWriteD`=1, `WA3D`=3), then SUB with `RA1D`=3.
  - Required: when SUB reaches E, `ForwardAE`=10, no stall.
  - With one NOP between them: `ForwardAE`=01.
- Load-use, `MEM_LAT`=1: LDR R5 then ADD with `RA2D`=5 -> `StallF`=`StallD`=`FlushE`=1 for 1 cycle, then `ForwardBE`=01 when ADD is in E, `stall_cnt`=1.
- Load-use, `MEM_LAT`=3: LDR R5 then dependent ADD -> stall for exactly 3 cycles, `stall_cnt`=3. An ALU producer at distance 1 with `MEM_LAT`=3 -> no stall, `ForwardAE`=10.
- Branch during stall:
  - Set up a load-use stall and assert `BranchTakenE` in the same cycle.
  - Required: `StallD`=0, `FlushD`=`FlushE`=1, `flush_cnt` +1, `stall_cnt` unchanged.
- Edge cases:
  - Producer writing R15 followed by `RA1D`=15 -> `ForwardAE`=00, no stall.
  - Hold a stall condition for 2^`CNT_W`+5 cycles (`CNT_W`=4) -> `stall_cnt` stays at 15.
